// File: rtl/rr_prio_arbiter.sv
// Registered N-way arbiter: search starts at a loadable pointer, optional
// round-robin rotation, grant held until request drops or MAX_HOLD expires.
module rr_prio_arbiter #(
    parameter int N        = 16,
    parameter int IDXW     = 4,
    parameter int MAX_HOLD = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            mode,
    input  logic [IDXW-1:0] pri_in,
    input  logic            pri_load,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic [N-1:0]    grant_onehot,
    output logic            zero,
    output logic            timeout
);

    typedef enum logic {IDLE, GRANTED} state_t;

    localparam logic [15:0] HOLD_LAST = 16'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [15:0]     hold_cnt;

    logic [IDXW-1:0] win;
    logic [IDXW-1:0] pri_mod;
    logic [IDXW-1:0] ptr_rot;
    logic            own_req;
    logic            hold_expired;

    // Circular search from ptr; the first set bit in ascending order wins.
    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                win   = IDXW'(j);
                found = 1'b1;
            end
        end
    end

    // pri_in is always < 2N, so one conditional subtract gives the modulo.
    assign pri_mod      = (int'(pri_in) >= N) ? pri_in - IDXW'(N) : pri_in;
    assign ptr_rot      = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    assign own_req      = req[grant_idx];
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            zero         <= 1'b1;
            timeout      <= 1'b0;
        end else begin
            zero    <= (req == '0);
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        grant_valid  <= 1'b1;
                        grant_idx    <= win;
                        grant_onehot <= N'(1) << win;
                        hold_cnt     <= '0;
                        state        <= GRANTED;
                    end else begin
                        grant_valid  <= 1'b0;
                        grant_onehot <= '0;
                    end
                end
                GRANTED: begin
                    if (!own_req || hold_expired) begin
                        grant_valid  <= 1'b0;
                        grant_onehot <= '0;
                        timeout      <= own_req;
                        state        <= IDLE;
                        if (mode) ptr <= ptr_rot;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A load overrides any rotation decided above on the same edge.
            if (pri_load) ptr <= pri_mod;
        end
    end

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Scoreboard bench: each driven cycle pushes its expected registered outputs,
// which the monitor pops and compares just after the following rising edge.
module tb_rr_prio_arbiter;

    localparam int N    = 16;
    localparam int IDXW = 4;

    typedef struct {
        logic            v;
        logic [IDXW-1:0] idx;
        logic            to;
        logic            z;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic            mode;
    logic [IDXW-1:0] pri_in;
    logic            pri_load;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic [N-1:0]    grant_onehot;
    logic            zero;
    logic            timeout;

    int    n_tests = 0;
    int    n_fail  = 0;
    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  e;
    string etag;
    logic [N-1:0] oh;

    always #5 clk = ~clk;

    rr_prio_arbiter #(.N(N), .IDXW(IDXW), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode), .pri_in(pri_in),
        .pri_load(pri_load), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .grant_onehot(grant_onehot), .zero(zero), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    // Drive one cycle at the falling edge, record what must appear after the next rise.
    task automatic cyc(input logic [N-1:0] r, input logic m, input logic pl,
                       input logic [IDXW-1:0] pi, input logic ev,
                       input logic [IDXW-1:0] ei, input logic eto, input string tag);
        exp_t x;
        req = r; mode = m; pri_load = pl; pri_in = pi;
        x.v = ev; x.idx = ei; x.to = eto; x.z = (r == '0);
        exp_q.push_back(x);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            etag = tag_q.pop_front();
            oh   = e.v ? (N'(1) << e.idx) : '0;
            chk({etag, ".valid"},   64'(grant_valid),  64'(e.v));
            chk({etag, ".idx"},     64'(grant_idx),    64'(e.idx));
            chk({etag, ".onehot"},  64'(grant_onehot), 64'(oh));
            chk({etag, ".zero"},    64'(zero),         64'(e.z));
            chk({etag, ".timeout"}, 64'(timeout),      64'(e.to));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 16'hFFFF; mode = 1'b0; pri_in = '0; pri_load = 1'b0;
        #12;
        chk("rst.valid",   64'(grant_valid),  64'd0);
        chk("rst.onehot",  64'(grant_onehot), 64'd0);
        chk("rst.idx",     64'(grant_idx),    64'd0);
        chk("rst.zero",    64'(zero),         64'd1);
        chk("rst.timeout", 64'(timeout),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        //   req       m     pl    pi     v     idx    to
        cyc(16'hFFFF, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0,  1'b0, "rst_grant");
        cyc(16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, "rst_rel");
        // fixed priority, search wraps past N-1
        cyc(16'h0000, 1'b0, 1'b1, 4'd10, 1'b0, 4'd0,  1'b0, "load10");
        cyc(16'h0021, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0,  1'b0, "fwrap");
        cyc(16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, "fwrap_rel");
        cyc(16'h0420, 1'b0, 1'b0, 4'd0,  1'b1, 4'd10, 1'b0, "fptr_kept");
        cyc(16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 4'd10, 1'b0, "fptr_rel");
        // fixed start points
        cyc(16'h0000, 1'b0, 1'b1, 4'd3,  1'b0, 4'd10, 1'b0, "load3");
        cyc(16'h2100, 1'b0, 1'b0, 4'd0,  1'b1, 4'd8,  1'b0, "fstart3");
        cyc(16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 4'd8,  1'b0, "fstart3_rel");
        cyc(16'h0000, 1'b0, 1'b1, 4'd13, 1'b0, 4'd8,  1'b0, "load13");
        cyc(16'h2100, 1'b0, 1'b0, 4'd0,  1'b1, 4'd13, 1'b0, "fstart13");
        cyc(16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 4'd13, 1'b0, "fstart13_rel");
        // round-robin with one idle cycle between grants
        cyc(16'h0000, 1'b1, 1'b1, 4'd0,  1'b0, 4'd13, 1'b0, "load0");
        cyc(16'h8005, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0,  1'b0, "rr0");
        cyc(16'h8004, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, "rr_gap0");
        cyc(16'h8004, 1'b1, 1'b0, 4'd0,  1'b1, 4'd2,  1'b0, "rr2");
        cyc(16'h8000, 1'b1, 1'b0, 4'd0,  1'b0, 4'd2,  1'b0, "rr_gap2");
        cyc(16'h8000, 1'b1, 1'b0, 4'd0,  1'b1, 4'd15, 1'b0, "rr15");
        cyc(16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 4'd15, 1'b0, "rr_gap15");
        cyc(16'h8001, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0,  1'b0, "rr_wrap");
        cyc(16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, "rr_wrap_rel");
        // load on the release edge beats rotation (rotation would give 6)
        cyc(16'h0021, 1'b1, 1'b0, 4'd0,  1'b1, 4'd5,  1'b0, "prec_g5");
        cyc(16'h0000, 1'b1, 1'b1, 4'd2,  1'b0, 4'd5,  1'b0, "prec_rel");
        cyc(16'h0048, 1'b1, 1'b0, 4'd0,  1'b1, 4'd3,  1'b0, "prec_g3");
        cyc(16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 4'd3,  1'b0, "prec_rel3");
        // timeout after exactly 4 grant cycles; a load mid-grant is harmless
        cyc(16'h0080, 1'b0, 1'b0, 4'd0,  1'b1, 4'd7,  1'b0, "to_c1");
        cyc(16'h0080, 1'b0, 1'b0, 4'd0,  1'b1, 4'd7,  1'b0, "to_c2");
        cyc(16'h0080, 1'b0, 1'b1, 4'd9,  1'b1, 4'd7,  1'b0, "to_c3");
        cyc(16'h0080, 1'b0, 1'b0, 4'd0,  1'b1, 4'd7,  1'b0, "to_c4");
        cyc(16'h0080, 1'b0, 1'b0, 4'd0,  1'b0, 4'd7,  1'b1, "to_pulse");
        cyc(16'h0080, 1'b0, 1'b0, 4'd0,  1'b1, 4'd7,  1'b0, "to_regrant");
        cyc(16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 4'd7,  1'b0, "to_rel");
        // async reset mid-grant (ptr is 9 here)
        cyc(16'h0020, 1'b0, 1'b0, 4'd0,  1'b1, 4'd5,  1'b0, "g5");
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid",  64'(grant_valid),  64'd0);
        chk("arst.onehot", 64'(grant_onehot), 64'd0);
        chk("arst.idx",    64'(grant_idx),    64'd0);
        @(negedge clk);
        rst = 1'b0;
        // ptr back at 0 picks 5; a surviving ptr of 9 would pick 10
        cyc(16'h0420, 1'b0, 1'b0, 4'd0,  1'b1, 4'd5,  1'b0, "post_rst");
        cyc(16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 4'd5,  1'b0, "post_rst_rel");
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
